unit_scheduler: RTL and testbench

UNIT_SCHEDULER -- requirements
Module: unit_scheduler

---
 rtl/accel_pkg.sv | 49 ++++
 rtl/sched_fifo.sv | 52 +++++
 rtl/unit_scheduler.sv | 163 ++++++++++++++++
 tb/tb_unit_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types for the unit scheduler: job encoding, per-unit control packet,
// scheduler state and packet builders.
package accel_pkg;
  localparam int NUM_PROCESSING_UNITS = 4;
  localparam int UNIT_W = 2;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_LOAD    = 2'b01,
    OP_STORE   = 2'b10,
    OP_COMPUTE = 2'b11
  } job_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } sched_state_e;

  typedef struct packed {
    logic [5:0] encoded_control;
    logic [7:0] data_control;
  } control_packet_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] ctype;
    logic [3:0] addr;
  } job_t;

  localparam int JOB_W = $bits(job_t);

  // Idle command for a unit: unit id only, no op, no data.
  function automatic control_packet_t nop_packet(input logic [UNIT_W-1:0] u);
    control_packet_t p;
    p.encoded_control = {u, 4'b0000};
    p.data_control    = 8'h00;
    return p;
  endfunction

  // Command for a unit receiving job j.
  function automatic control_packet_t issue_packet(input logic [UNIT_W-1:0] u,
                                                   input job_t j);
    control_packet_t p;
    p.encoded_control = {u, j.op, j.ctype};
    p.data_control    = {j.addr, 1'b1, 3'b111};
    return p;
  endfunction
endpackage

// File: rtl/sched_fifo.sv
// Job queue: circular buffer with registered occupancy count and flush.
module sched_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full queue refuses a push even when the same cycle pops.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;

  // Pointers and occupancy; flush returns to empty.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
endmodule

// File: rtl/unit_scheduler.sv
// Dispatches queued jobs to processing units with round-robin grant,
// per-unit busy tracking and watchdog, and an IDLE/RUN/DRAIN controller.
module unit_scheduler
  import accel_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       sched_enable,
  input  logic                                       drain_req,
  input  logic                                       flush,
  input  logic                                       job_valid,
  output logic                                       job_ready,
  input  logic [1:0]                                 job_op,
  input  logic [1:0]                                 job_ctype,
  input  logic [3:0]                                 job_addr,
  output control_packet_t [NUM_PROCESSING_UNITS-1:0] unit_control,
  output logic [NUM_PROCESSING_UNITS-1:0]            unit_issue,
  input  logic [NUM_PROCESSING_UNITS-1:0]            unit_ready,
  input  logic [NUM_PROCESSING_UNITS-1:0]            unit_done,
  output logic [1:0]                                 sched_state,
  output logic                                       drain_done,
  output logic [NUM_PROCESSING_UNITS-1:0]            timeout_flag,
  output logic [15:0]                                jobs_done
);
  localparam int N     = NUM_PROCESSING_UNITS;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_e       state_q;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_empty;
  logic [JOB_W-1:0]   fifo_dout;
  job_t               head_job, in_job;
  logic               push;
  logic [N-1:0]       busy, done_acc, grant_vec;
  logic [UNIT_W-1:0]  grant_idx, rr_ptr;
  logic               grant_any, can_issue;
  logic [15:0]        done_cnt;

  assign job_ready = !rst && (fifo_cnt < CNT_W'(FIFO_DEPTH))
                     && (state_q != ST_DRAIN) && !drain_req;
  // NOP jobs complete the handshake but never enter the queue.
  assign push      = job_valid && job_ready && (job_op != OP_NOP) && !flush;
  assign in_job    = '{op: job_op, ctype: job_ctype, addr: job_addr};
  assign head_job  = job_t'(fifo_dout);
  assign can_issue = (state_q == ST_RUN || state_q == ST_DRAIN) && !fifo_empty;
  assign sched_state = state_q;

  sched_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(JOB_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (grant_any),
    .flush (flush),
    .din   (in_job),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // Round-robin search from rr_ptr over idle, ready units; first hit wins.
  always_comb begin
    logic [UNIT_W-1:0] idx;
    idx       = '0;
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = rr_ptr + UNIT_W'(k);
      if (can_issue && !grant_any && unit_ready[idx] && !busy[idx]) begin
        grant_any      = 1'b1;
        grant_vec[idx] = 1'b1;
        grant_idx      = idx;
      end
    end
  end

  // Next search starts at the unit after the one just granted.
  always_ff @(posedge clk or posedge rst)
    if (rst)            rr_ptr <= '0;
    else if (grant_any) rr_ptr <= (grant_idx == UNIT_W'(N-1)) ? '0 : grant_idx + 1'b1;

  // Per-unit command register, busy flag and watchdog.
  for (genvar i = 0; i < N; i++) begin : g_unit
    logic            busy_q, flag_q, issue_q;
    logic [WD_W-1:0] wdog_q;
    control_packet_t ctrl_q;

    assign busy[i]         = busy_q;
    assign timeout_flag[i] = flag_q;
    assign unit_issue[i]   = issue_q;
    assign unit_control[i] = ctrl_q;
    assign done_acc[i]     = unit_done[i] && busy_q;

    // Grant sets busy; a done pulse or watchdog expiry releases it.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        busy_q  <= 1'b0;
        flag_q  <= 1'b0;
        issue_q <= 1'b0;
        wdog_q  <= '0;
        ctrl_q  <= nop_packet(UNIT_W'(i));
      end else begin
        issue_q <= grant_vec[i];
        ctrl_q  <= grant_vec[i] ? issue_packet(UNIT_W'(i), head_job)
                                : nop_packet(UNIT_W'(i));
        if (flush) flag_q <= 1'b0;
        if (grant_vec[i]) begin
          busy_q <= 1'b1;
          wdog_q <= '0;
        end else if (busy_q) begin
          if (unit_done[i]) begin
            busy_q <= 1'b0;
            wdog_q <= '0;
          end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            busy_q <= 1'b0;
            wdog_q <= '0;
            flag_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
      end
  end

  // Several units may complete in the same cycle.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < N; i++) done_cnt = done_cnt + 16'(done_acc[i]);
  end

  // Wrapping completed-job counter.
  always_ff @(posedge clk or posedge rst)
    if (rst) jobs_done <= '0;
    else     jobs_done <= jobs_done + done_cnt;

  // Controller; DRAIN from IDLE only when there is work left, so a held
  // drain_req does not keep re-pulsing drain_done on an empty scheduler.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= ST_IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      unique case (state_q)
        ST_IDLE:
          if (drain_req && (!fifo_empty || (busy != '0))) state_q <= ST_DRAIN;
          else if (sched_enable)                          state_q <= ST_RUN;
        ST_RUN:
          if (drain_req)          state_q <= ST_DRAIN;
          else if (!sched_enable) state_q <= ST_IDLE;
        ST_DRAIN:
          if (fifo_empty && (busy == '0)) begin
            state_q    <= ST_IDLE;
            drain_done <= 1'b1;
          end
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_unit_scheduler.sv
// Directed bench for unit_scheduler with hand-computed expectations.
module tb_unit_scheduler;
  import accel_pkg::*;
  localparam int N = NUM_PROCESSING_UNITS;

  logic clk = 1'b0, rst = 1'b1;
  logic sched_enable = 1'b0, drain_req = 1'b0, flush = 1'b0, job_valid = 1'b0;
  logic job_ready;
  logic [1:0] job_op = '0, job_ctype = '0;
  logic [3:0] job_addr = '0;
  control_packet_t [N-1:0] unit_control;
  logic [N-1:0] unit_issue, unit_ready = '0, unit_done = '0, timeout_flag;
  logic [1:0]  sched_state;
  logic        drain_done;
  logic [15:0] jobs_done;

  int n_tests = 0, n_fail = 0;

  unit_scheduler #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .sched_enable(sched_enable), .drain_req(drain_req),
    .flush(flush), .job_valid(job_valid), .job_ready(job_ready),
    .job_op(job_op), .job_ctype(job_ctype), .job_addr(job_addr),
    .unit_control(unit_control), .unit_issue(unit_issue),
    .unit_ready(unit_ready), .unit_done(unit_done), .sched_state(sched_state),
    .drain_done(drain_done), .timeout_flag(timeout_flag), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] ct, input logic [3:0] a);
    job_valid = 1'b1; job_op = op; job_ctype = ct; job_addr = a;
    tick();
    job_valid = 1'b0;
  endtask

  // Count issue strobes over a window and record which units were hit.
  task automatic collect(input int cycles, output int cnt, output logic [N-1:0] mask);
    cnt = 0; mask = '0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      for (int u = 0; u < N; u++)
        if (unit_issue[u]) begin cnt++; mask[u] = 1'b1; end
    end
  endtask

  function automatic logic [13:0] exp_iss(input int u, input logic [1:0] op,
                                          input logic [1:0] ct, input logic [3:0] a);
    return {2'(u), op, ct, a, 4'b1111};
  endfunction

  function automatic logic [13:0] exp_nop(input int u);
    return {2'(u), 12'h000};
  endfunction

  int cnt, n_iss;
  logic [N-1:0] mask;

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_ready", 32'(job_ready), 32'd0);
    chk("rst_state", 32'(sched_state), 32'd0);
    chk("rst_issue", 32'(unit_issue), 32'd0);
    chk("rst_ctrl0", 32'(unit_control[0]), 32'(exp_nop(0)));
    chk("rst_ctrl3", 32'(unit_control[3]), 32'(14'h3000));
    chk("rst_flags", 32'(timeout_flag), 32'd0);
    chk("rst_jobs",  32'(jobs_done), 32'd0);
    chk("rst_ddone", 32'(drain_done), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(job_ready), 32'd1);

    // Four compute jobs go to units 0..3 on consecutive cycles
    sched_enable = 1'b1; unit_ready = 4'hF;
    tick();
    chk("state_run", 32'(sched_state), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      push(2'b11, 2'b01, 4'(k));
      if (k >= 2) begin
        chk($sformatf("rr_issue%0d", k-2), 32'(unit_issue), 32'(4'(1 << (k-2))));
        chk($sformatf("rr_ctrl%0d", k-2), 32'(unit_control[k-2]),
            32'(exp_iss(k-2, 2'b11, 2'b01, 4'(k-1))));
      end
      if (k == 2) chk("rr_nop3", 32'(unit_control[3]), 32'(exp_nop(3)));
    end
    tick();
    chk("rr_issue3", 32'(unit_issue), 32'h8);
    chk("rr_ctrl3", 32'(unit_control[3]), 32'(exp_iss(3, 2'b11, 2'b01, 4'd4)));
    tick();
    chk("rr_idle_issue", 32'(unit_issue), 32'd0);
    chk("rr_idle_ctrl0", 32'(unit_control[0]), 32'(exp_nop(0)));
    unit_done = 4'hF;
    tick();
    unit_done = '0;
    chk("jobs_after4", 32'(jobs_done), 32'd4);

    // Done on an idle unit is ignored
    unit_done = 4'b0010;
    tick();
    unit_done = '0;
    tick();
    chk("idle_done_jobs", 32'(jobs_done), 32'd4);
    chk("idle_done_state", 32'(sched_state), 32'd1);

    // Fill the queue while disabled, then run it out in order
    sched_enable = 1'b0;
    tick();
    chk("state_idle", 32'(sched_state), 32'd0);
    for (int k = 0; k < 8; k++) push(2'b01, 2'b00, 4'(k));
    job_valid = 1'b1;
    #1;
    chk("full_ready", 32'(job_ready), 32'd0);
    chk("idle_no_issue", 32'(unit_issue), 32'd0);
    job_valid = 1'b0;
    sched_enable = 1'b1; unit_done = 4'hF;
    n_iss = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int u = 0; u < N; u++)
        if (unit_issue[u]) begin
          chk($sformatf("fifo_order%0d", n_iss), 32'(unit_control[u].data_control),
              32'({4'(n_iss), 4'b1111}));
          n_iss++;
        end
    end
    unit_done = '0;
    chk("fifo_issued", 32'(n_iss), 32'd8);
    chk("jobs_after12", 32'(jobs_done), 32'd12);

    // NOP job is handshaken but never issued
    job_valid = 1'b1; job_op = 2'b00; job_addr = 4'd5;
    #1;
    chk("nop_ready", 32'(job_ready), 32'd1);
    tick();
    job_valid = 1'b0;
    collect(3, cnt, mask);
    chk("nop_dropped", 32'(cnt), 32'd0);

    // Watchdog on unit 2
    unit_ready = 4'b0100;
    push(2'b11, 2'b10, 4'd9);
    tick();
    chk("wd_issue", 32'(unit_issue), 32'h4);
    for (int c = 0; c < 15; c++) tick();
    chk("wd_before", 32'(timeout_flag), 32'd0);
    tick();
    chk("wd_flag", 32'(timeout_flag), 32'h4);
    chk("wd_jobs", 32'(jobs_done), 32'd12);
    unit_ready = 4'hF;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_flag", 32'(timeout_flag), 32'd0);

    // Flush discards queue and a same-cycle push
    sched_enable = 1'b0;
    tick();
    push(2'b01, 2'b00, 4'd1);
    push(2'b10, 2'b00, 4'd2);
    flush = 1'b1;
    push(2'b11, 2'b00, 4'd3);
    flush = 1'b0;
    sched_enable = 1'b1;
    collect(6, cnt, mask);
    chk("flush_queue", 32'(cnt), 32'd0);

    // Drain with scheduling disabled
    sched_enable = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) push(2'b11, 2'b00, 4'(k + 10));
    drain_req = 1'b1;
    #1;
    chk("drain_ready", 32'(job_ready), 32'd0);
    tick();
    chk("drain_state", 32'(sched_state), 32'd2);
    collect(5, cnt, mask);
    chk("drain_issued", 32'(cnt), 32'd3);
    chk("drain_wait", 32'(drain_done), 32'd0);
    unit_done = mask;
    tick();
    unit_done = '0;
    chk("drain_hold", 32'(sched_state), 32'd2);
    chk("drain_nopulse", 32'(drain_done), 32'd0);
    tick();
    chk("drain_pulse", 32'(drain_done), 32'd1);
    chk("drain_idle", 32'(sched_state), 32'd0);
    tick();
    chk("drain_single", 32'(drain_done), 32'd0);
    chk("jobs_after15", 32'(jobs_done), 32'd15);
    drain_req = 1'b0;

    // Reset mid-operation: 2 busy, 5 queued
    sched_enable = 1'b1; unit_ready = 4'b0011;
    tick();
    for (int k = 0; k < 7; k++) push(2'b01, 2'b00, 4'(k));
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_state", 32'(sched_state), 32'd0);
    chk("mrst_issue", 32'(unit_issue), 32'd0);
    chk("mrst_ready", 32'(job_ready), 32'd0);
    chk("mrst_jobs", 32'(jobs_done), 32'd0);
    chk("mrst_ctrl1", 32'(unit_control[1]), 32'(14'h1000));
    chk("mrst_ddone", 32'(drain_done), 32'd0);
    rst = 1'b0; unit_done = 4'b0011; unit_ready = 4'hF;
    tick();
    unit_done = '0;
    collect(4, cnt, mask);
    chk("mrst_noissue", 32'(cnt), 32'd0);
    chk("mrst_done_ign", 32'(jobs_done), 32'd0);
    chk("mrst_run", 32'(sched_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
